// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - widths, memory op codes, FSM states and decode helpers for mem_access
package mem_access_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int ADDR_WIDTH     = 32;
   localparam int RDATA_WIDTH    = 32;
   localparam int RADDR_WIDTH    = 5;
   localparam int CSR_ADDR_WIDTH = 12;
   localparam int CNT_WIDTH      = 8;

   localparam logic [RDATA_WIDTH-1:0]    ZERO          = '0;
   localparam logic [RADDR_WIDTH-1:0]    ZERO_REG      = '0;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ZERO_ADDR = '0;

   typedef enum logic [3:0] {
      OP_NONE = 4'b0000,
      OP_LB   = 4'b0001,
      OP_LH   = 4'b0010,
      OP_LW   = 4'b0011,
      OP_LBU  = 4'b0100,
      OP_LHU  = 4'b0101,
      OP_SB   = 4'b0110,
      OP_SH   = 4'b0111,
      OP_SW   = 4'b1000
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A load code paired with a store flag (or the reverse) is not a memory op.
   function automatic mem_op_e decode_op(input logic [3:0] code, input logic we);
      mem_op_e op;
      op = OP_NONE;
      case (code)
         4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: if (!we) op = mem_op_e'(code);
         4'b0110, 4'b0111, 4'b1000:                   if (we)  op = mem_op_e'(code);
         default:                                     op = OP_NONE;
      endcase
      return op;
   endfunction

   function automatic logic is_store(input mem_op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
      case (op)
         OP_LH, OP_LHU, OP_SH: return addr_lo[0];
         OP_LW, OP_SW:         return addr_lo != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_align.sv
// rtl/mem_access_align.sv - byte-lane placement for stores and lane extraction/extension for loads
module mem_align
   import mem_access_pkg::*;
(
   input  mem_op_e                 op,
   input  logic [1:0]              addr_lo,
   input  logic [DATA_WIDTH-1:0]   store_data,
   input  logic [DATA_WIDTH-1:0]   load_word,
   output logic [3:0]              be,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [RDATA_WIDTH-1:0]  load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Byte enables, replicated store data and extended load value from op and address lane
   always_comb begin
      be        = 4'b0000;
      wdata     = '0;
      load_data = ZERO;
      sel_byte  = load_word[{addr_lo, 3'b000} +: 8];
      sel_half  = load_word[{addr_lo[1], 4'b0000} +: 16];

      case (op)
         OP_LB, OP_LBU, OP_SB: be = 4'b0001 << addr_lo;
         OP_LH, OP_LHU, OP_SH: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         OP_LW, OP_SW:         be = 4'b1111;
         default:              be = 4'b0000;
      endcase

      case (op)
         OP_SB:   wdata = {4{store_data[7:0]}};
         OP_SH:   wdata = {2{store_data[15:0]}};
         OP_SW:   wdata = store_data;
         default: wdata = '0;
      endcase

      case (op)
         OP_LB:   load_data = {{(RDATA_WIDTH-8){sel_byte[7]}}, sel_byte};
         OP_LBU:  load_data = {{(RDATA_WIDTH-8){1'b0}}, sel_byte};
         OP_LH:   load_data = {{(RDATA_WIDTH-16){sel_half[15]}}, sel_half};
         OP_LHU:  load_data = {{(RDATA_WIDTH-16){1'b0}}, sel_half};
         OP_LW:   load_data = load_word;
         default: load_data = ZERO;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: data-bus access FSM with stall, misalign and timeout handling
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic                      clk_in,
   input  logic                      reset_n_in,
   input  logic [RDATA_WIDTH-1:0]    reg_wdata_in,
   input  logic [RADDR_WIDTH-1:0]    reg_waddr_in,
   input  logic                      reg_we_in,
   input  logic [DATA_WIDTH-1:0]     mem_data_in,
   input  logic [ADDR_WIDTH-1:0]     mem_addr_in,
   input  logic                      mem_we_in,
   input  logic [3:0]                mem_op_in,
   input  logic                      csr_we_in,
   input  logic [RDATA_WIDTH-1:0]    csr_wdata_in,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_in,
   output logic                      dbus_req_out,
   output logic                      dbus_we_out,
   output logic [ADDR_WIDTH-1:0]     dbus_addr_out,
   output logic [DATA_WIDTH-1:0]     dbus_wdata_out,
   output logic [3:0]                dbus_be_out,
   input  logic                      dbus_ack_in,
   input  logic [DATA_WIDTH-1:0]     dbus_rdata_in,
   output logic                      stall_req_out,
   output logic [RDATA_WIDTH-1:0]    reg_wdata_out,
   output logic [RADDR_WIDTH-1:0]    reg_waddr_out,
   output logic                      reg_we_out,
   output logic                      csr_we_out,
   output logic [RDATA_WIDTH-1:0]    csr_wdata_out,
   output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_out,
   output logic                      misalign_out,
   output logic                      bus_err_out
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   state_e                  state_q, state_d;
   mem_op_e                 op_q;
   mem_op_e                 op_in;
   logic                    mis_in;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic                    err_q;
   logic [3:0]              al_be;
   logic [DATA_WIDTH-1:0]   al_wdata;
   logic [RDATA_WIDTH-1:0]  al_load;

   assign op_in  = decode_op(mem_op_in, mem_we_in);
   assign mis_in = is_misaligned(op_in, mem_addr_in[1:0]);

   mem_align u_align (
      .op         (op_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (data_q),
      .load_word  (rdata_q),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   // FSM state register
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   // Next state: aligned op starts a bus access; ack or wait-count expiry ends it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (op_in != OP_NONE && !mis_in) state_d = ST_REQ;
         ST_REQ:  if (dbus_ack_in || cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Access registers: latch the request in IDLE, then count waits and capture read data in REQ
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         op_q    <= OP_NONE;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (state_d == ST_REQ) begin
                  op_q   <= op_in;
                  addr_q <= mem_addr_in;
                  data_q <= mem_data_in;
                  cnt_q  <= '0;
                  err_q  <= 1'b0;
               end
            end
            ST_REQ: begin
               if (dbus_ack_in)            rdata_q <= dbus_rdata_in;
               else if (cnt_q == CNT_LAST) err_q   <= 1'b1;
               else                        cnt_q   <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs: pass-through by default, bus drive only in REQ, load result and error in DONE
   always_comb begin
      dbus_req_out   = 1'b0;
      dbus_we_out    = 1'b0;
      dbus_be_out    = 4'b0000;
      dbus_addr_out  = '0;
      dbus_wdata_out = '0;
      stall_req_out  = 1'b0;
      misalign_out   = 1'b0;
      bus_err_out    = 1'b0;
      reg_wdata_out  = reg_wdata_in;
      reg_waddr_out  = reg_waddr_in;
      reg_we_out     = reg_we_in;
      csr_we_out     = csr_we_in;
      csr_wdata_out  = csr_wdata_in;
      csr_waddr_out  = csr_waddr_in;
      if (!reset_n_in) begin
         reg_wdata_out = ZERO;
         reg_waddr_out = ZERO_REG;
         reg_we_out    = 1'b0;
         csr_we_out    = 1'b0;
         csr_wdata_out = ZERO;
         csr_waddr_out = CSR_ZERO_ADDR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (op_in != OP_NONE) begin
                  reg_we_out = 1'b0;
                  csr_we_out = 1'b0;
                  if (mis_in) misalign_out  = 1'b1;
                  else        stall_req_out = 1'b1;
               end
            end
            ST_REQ: begin
               dbus_req_out   = 1'b1;
               dbus_we_out    = is_store(op_q);
               dbus_be_out    = al_be;
               dbus_addr_out  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
               dbus_wdata_out = al_wdata;
               stall_req_out  = 1'b1;
               reg_we_out     = 1'b0;
               csr_we_out     = 1'b0;
            end
            ST_DONE: begin
               if (err_q) begin
                  bus_err_out = 1'b1;
                  reg_we_out  = 1'b0;
               end else if (!is_store(op_q)) begin
                  reg_wdata_out = al_load;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access with a transaction-level reference model
module tb_mem_access;

   localparam int TMO = 4;

   logic        clk_in = 1'b0;
   logic        reset_n_in;
   logic [31:0] reg_wdata_in;
   logic [4:0]  reg_waddr_in;
   logic        reg_we_in;
   logic [31:0] mem_data_in, mem_addr_in;
   logic        mem_we_in;
   logic [3:0]  mem_op_in;
   logic        csr_we_in;
   logic [31:0] csr_wdata_in;
   logic [11:0] csr_waddr_in;
   logic        dbus_req_out, dbus_we_out;
   logic [31:0] dbus_addr_out, dbus_wdata_out;
   logic [3:0]  dbus_be_out;
   logic        dbus_ack_in;
   logic [31:0] dbus_rdata_in;
   logic        stall_req_out;
   logic [31:0] reg_wdata_out;
   logic [4:0]  reg_waddr_out;
   logic        reg_we_out, csr_we_out;
   logic [31:0] csr_wdata_out;
   logic [11:0] csr_waddr_out;
   logic        misalign_out, bus_err_out;

   always #5 clk_in = ~clk_in;

   mem_access #(.TIMEOUT(TMO)) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in),
      .reg_wdata_in(reg_wdata_in), .reg_waddr_in(reg_waddr_in), .reg_we_in(reg_we_in),
      .mem_data_in(mem_data_in), .mem_addr_in(mem_addr_in), .mem_we_in(mem_we_in),
      .mem_op_in(mem_op_in),
      .csr_we_in(csr_we_in), .csr_wdata_in(csr_wdata_in), .csr_waddr_in(csr_waddr_in),
      .dbus_req_out(dbus_req_out), .dbus_we_out(dbus_we_out),
      .dbus_addr_out(dbus_addr_out), .dbus_wdata_out(dbus_wdata_out),
      .dbus_be_out(dbus_be_out), .dbus_ack_in(dbus_ack_in), .dbus_rdata_in(dbus_rdata_in),
      .stall_req_out(stall_req_out),
      .reg_wdata_out(reg_wdata_out), .reg_waddr_out(reg_waddr_out), .reg_we_out(reg_we_out),
      .csr_we_out(csr_we_out), .csr_wdata_out(csr_wdata_out), .csr_waddr_out(csr_waddr_out),
      .misalign_out(misalign_out), .bus_err_out(bus_err_out)
   );

   int checks = 0;
   int failures = 0;

   // observations recorded by drive_txn
   logic        o_idle_stall, o_idle_req, o_idle_mis, o_idle_reg_we, o_idle_csr_we;
   int          o_stall_cycles, o_req_cycles;
   logic        o_stable;
   logic [3:0]  o_be;
   logic [31:0] o_addr, o_wdata;
   logic        o_we;
   logic        o_done_stall, o_done_req, o_done_reg_we, o_done_csr_we, o_done_err;
   logic [31:0] o_done_reg_wdata, o_done_csr_wdata;
   logic [4:0]  o_done_reg_waddr;
   logic [11:0] o_done_csr_waddr;

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [3:0] code);
      case (code)
         4'd1, 4'd4, 4'd6: return 1;
         4'd2, 4'd5, 4'd7: return 2;
         4'd3, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic bit op_store(input logic [3:0] code);
      return code >= 4'd6 && code <= 4'd8;
   endfunction

   function automatic bit op_valid(input logic [3:0] code, input logic we);
      return (code >= 4'd1 && code <= 4'd5 && !we) || (op_store(code) && we);
   endfunction

   function automatic bit op_misaligned(input logic [3:0] code, input logic [31:0] a);
      int sz;
      sz = op_size(code);
      return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [3:0] exp_be(input logic [3:0] code, input logic [31:0] a);
      int sz, lane;
      sz = op_size(code);
      lane = int'(a[1:0]);
      if (sz == 1) return 4'(1 << lane);
      if (sz == 2) return 4'(3 << (lane / 2 * 2));
      return 4'hf;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [3:0] code, input logic [31:0] d);
      int sz;
      sz = op_size(code);
      if (sz == 1) return (d & 32'hff) * 32'h01010101;
      if (sz == 2) return (d & 32'hffff) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] r);
      int sz, lane;
      logic [31:0] mask, v;
      sz = op_size(code);
      if (sz == 4) return r;
      lane = (sz == 2) ? int'(a[1:0]) / 2 * 2 : int'(a[1:0]);
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = (r >> (8 * lane)) & mask;
      if ((code == 4'd1 || code == 4'd2) && v[8 * sz - 1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- stimulus driver (records observations only) ----------------
   task automatic drive_txn(input logic [3:0] code, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdata,
                            input int ack_at, input logic rwe);
      int cyc;
      @(posedge clk_in); #1;
      mem_op_in = code; mem_we_in = we; mem_addr_in = addr; mem_data_in = data;
      reg_wdata_in = $urandom; reg_waddr_in = 5'($urandom); reg_we_in = rwe;
      csr_we_in = 1'($urandom); csr_wdata_in = $urandom; csr_waddr_in = 12'($urandom);
      dbus_ack_in = 1'($urandom); dbus_rdata_in = $urandom;
      @(negedge clk_in);
      o_idle_stall = stall_req_out; o_idle_req = dbus_req_out; o_idle_mis = misalign_out;
      o_idle_reg_we = reg_we_out; o_idle_csr_we = csr_we_out;
      o_stall_cycles = 0; o_req_cycles = 0; o_stable = 1'b1; cyc = 0;
      while (stall_req_out === 1'b1 && cyc < 12) begin
         o_stall_cycles++;
         if (dbus_req_out === 1'b1) begin
            if (o_req_cycles == 0) begin
               o_be = dbus_be_out; o_addr = dbus_addr_out;
               o_wdata = dbus_wdata_out; o_we = dbus_we_out;
            end else if ({dbus_be_out, dbus_addr_out, dbus_wdata_out, dbus_we_out}
                         !== {o_be, o_addr, o_wdata, o_we}) begin
               o_stable = 1'b0;
            end
            o_req_cycles++;
         end
         @(posedge clk_in); #1;
         cyc++;
         dbus_ack_in = (cyc == ack_at) ? 1'b1 : 1'b0;
         dbus_rdata_in = (cyc == ack_at) ? rdata : $urandom;
         @(negedge clk_in);
      end
      o_done_stall = stall_req_out; o_done_req = dbus_req_out;
      o_done_reg_we = reg_we_out; o_done_csr_we = csr_we_out; o_done_err = bus_err_out;
      o_done_reg_wdata = reg_wdata_out; o_done_csr_wdata = csr_wdata_out;
      o_done_reg_waddr = reg_waddr_out; o_done_csr_waddr = csr_waddr_out;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset_n_in = 1'b0;
      mem_op_in = 4'd3; mem_we_in = 1'b0; mem_addr_in = 32'h100; mem_data_in = $urandom;
      reg_wdata_in = $urandom; reg_waddr_in = 5'd7; reg_we_in = 1'b1;
      csr_we_in = 1'b1; csr_wdata_in = $urandom; csr_waddr_in = 12'h305;
      dbus_ack_in = 1'b1; dbus_rdata_in = $urandom;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      checks++;
      if ({dbus_req_out, dbus_we_out, dbus_be_out, dbus_addr_out, dbus_wdata_out} !== 70'd0) begin
         failures++;
         $display("FAIL reset_dbus got req=%b we=%b be=%h addr=%h wdata=%h want all zero",
                  dbus_req_out, dbus_we_out, dbus_be_out, dbus_addr_out, dbus_wdata_out);
      end
      checks++;
      if ({stall_req_out, reg_we_out, csr_we_out, misalign_out, bus_err_out} !== 5'd0) begin
         failures++;
         $display("FAIL reset_flags got stall=%b reg_we=%b csr_we=%b mis=%b err=%b want 0",
                  stall_req_out, reg_we_out, csr_we_out, misalign_out, bus_err_out);
      end
      checks++;
      if ({reg_wdata_out, reg_waddr_out, csr_wdata_out, csr_waddr_out} !== 81'd0) begin
         failures++;
         $display("FAIL reset_regs got rwd=%h rwa=%h cwd=%h cwa=%h want zero",
                  reg_wdata_out, reg_waddr_out, csr_wdata_out, csr_waddr_out);
      end
      mem_op_in = 4'd0; dbus_ack_in = 1'b0;
      reset_n_in = 1'b1;
   endtask

   task automatic test_lw_wait;
      drive_txn(4'd3, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b1);
      checks++;
      if (o_stall_cycles != 4 || o_req_cycles != 3) begin
         failures++;
         $display("FAIL lw_wait_cycles got stall=%0d req=%0d want stall=4 req=3",
                  o_stall_cycles, o_req_cycles);
      end
      checks++;
      if ({o_addr, o_be, o_we} !== {32'h100, 4'hf, 1'b0}) begin
         failures++;
         $display("FAIL lw_wait_bus got addr=%h be=%h we=%b want 100 f 0", o_addr, o_be, o_we);
      end
      checks++;
      if (o_done_reg_wdata !== 32'hDEADBEEF || o_done_reg_we !== 1'b1 || o_done_stall !== 1'b0) begin
         failures++;
         $display("FAIL lw_wait_done got wdata=%h we=%b stall=%b want deadbeef 1 0",
                  o_done_reg_wdata, o_done_reg_we, o_done_stall);
      end
   endtask

   task automatic test_byte_loads;
      drive_txn(4'd1, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b1);
      checks++;
      if (o_done_reg_wdata !== 32'hFFFFFF80 || o_be !== 4'b1000) begin
         failures++;
         $display("FAIL lb_sign got wdata=%h be=%b want ffffff80 1000", o_done_reg_wdata, o_be);
      end
      drive_txn(4'd4, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b1);
      checks++;
      if (o_done_reg_wdata !== 32'h00000080) begin
         failures++;
         $display("FAIL lbu_zero got wdata=%h want 00000080", o_done_reg_wdata);
      end
   endtask

   task automatic test_store_half;
      drive_txn(4'd7, 1'b1, 32'h102, 32'h0000ABCD, 32'h0, 2, 1'b0);
      checks++;
      if ({o_be, o_wdata, o_we, o_addr} !== {4'b1100, 32'hABCDABCD, 1'b1, 32'h100}) begin
         failures++;
         $display("FAIL sh_lanes got be=%b wdata=%h we=%b addr=%h want 1100 abcdabcd 1 100",
                  o_be, o_wdata, o_we, o_addr);
      end
   endtask

   task automatic test_misalign;
      drive_txn(4'd3, 1'b0, 32'h101, 32'h0, 32'h0, 1, 1'b1);
      checks++;
      if ({o_idle_mis, o_idle_req, o_idle_stall, o_idle_reg_we, o_idle_csr_we} !== 5'b10000
          || o_req_cycles != 0) begin
         failures++;
         $display("FAIL misalign_lw got mis=%b req=%b stall=%b rwe=%b cwe=%b reqcyc=%0d want 1 0 0 0 0 0",
                  o_idle_mis, o_idle_req, o_idle_stall, o_idle_reg_we, o_idle_csr_we, o_req_cycles);
      end
   endtask

   task automatic test_timeout;
      drive_txn(4'd8, 1'b1, 32'h40, 32'h12345678, 32'h0, 0, 1'b1);
      checks++;
      if (o_stall_cycles != TMO + 1 || o_req_cycles != TMO || o_stable !== 1'b1) begin
         failures++;
         $display("FAIL timeout_cycles got stall=%0d req=%0d stable=%b want %0d %0d 1",
                  o_stall_cycles, o_req_cycles, o_stable, TMO + 1, TMO);
      end
      checks++;
      if (o_done_err !== 1'b1 || o_done_reg_we !== 1'b0 || o_done_stall !== 1'b0) begin
         failures++;
         $display("FAIL timeout_done got err=%b rwe=%b stall=%b want 1 0 0",
                  o_done_err, o_done_reg_we, o_done_stall);
      end
      drive_txn(4'd0, 1'b0, $urandom, $urandom, 32'h0, 0, 1'b1);
      checks++;
      if (o_idle_stall !== 1'b0 || o_done_err !== 1'b0 || o_done_reg_wdata !== reg_wdata_in) begin
         failures++;
         $display("FAIL timeout_back_idle got stall=%b err=%b rwd=%h want 0 0 %h",
                  o_idle_stall, o_done_err, o_done_reg_wdata, reg_wdata_in);
      end
   endtask

   task automatic test_reset_in_req;
      @(posedge clk_in); #1;
      mem_op_in = 4'd3; mem_we_in = 1'b0; mem_addr_in = 32'h200; dbus_ack_in = 1'b0;
      @(posedge clk_in); #1;
      @(negedge clk_in);
      checks++;
      if (dbus_req_out !== 1'b1) begin
         failures++;
         $display("FAIL rst_req_entry got req=%b want 1", dbus_req_out);
      end
      #1 reset_n_in = 1'b0;
      #1;
      checks++;
      if (dbus_req_out !== 1'b0 || stall_req_out !== 1'b0) begin
         failures++;
         $display("FAIL rst_req_abort got req=%b stall=%b want 0 0", dbus_req_out, stall_req_out);
      end
      @(posedge clk_in); #1;
      reset_n_in = 1'b1;
      mem_op_in = 4'd0; reg_wdata_in = $urandom; reg_we_in = 1'b1;
      dbus_ack_in = 1'b1; dbus_rdata_in = $urandom;
      @(negedge clk_in);
      checks++;
      if (dbus_req_out !== 1'b0 || stall_req_out !== 1'b0 || reg_wdata_out !== reg_wdata_in) begin
         failures++;
         $display("FAIL rst_late_ack got req=%b stall=%b rwd=%h want 0 0 %h",
                  dbus_req_out, stall_req_out, reg_wdata_out, reg_wdata_in);
      end
      @(posedge clk_in); #1;
      dbus_ack_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if (dbus_req_out !== 1'b0 || bus_err_out !== 1'b0 || reg_wdata_out !== reg_wdata_in) begin
         failures++;
         $display("FAIL rst_after_ack got req=%b err=%b rwd=%h want 0 0 %h",
                  dbus_req_out, bus_err_out, reg_wdata_out, reg_wdata_in);
      end
      drive_txn(4'd3, 1'b0, 32'h204, 32'h0, 32'h13579BDF, 1, 1'b1);
      checks++;
      if (o_done_reg_wdata !== 32'h13579BDF || o_stall_cycles != 2) begin
         failures++;
         $display("FAIL rst_fresh_lw got wdata=%h stall=%0d want 13579bdf 2",
                  o_done_reg_wdata, o_stall_cycles);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         logic [3:0]  code;
         logic        we, valid, mis, acc, tmo;
         logic [31:0] addr, data, rdata;
         int          ack_at, nreq;
         code = 4'($urandom_range(0, 10));
         we = op_store(code);
         if ($urandom_range(0, 9) == 0) we = ~we;
         addr = $urandom; data = $urandom; rdata = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         ack_at = $urandom_range(0, TMO + 1);
         drive_txn(code, we, addr, data, rdata, ack_at, 1'($urandom));
         valid = op_valid(code, we);
         mis = valid && op_misaligned(code, addr);
         acc = valid && !mis;
         tmo = (ack_at == 0) || (ack_at > TMO);
         nreq = acc ? (tmo ? TMO : ack_at) : 0;
         checks++;
         if (o_stall_cycles != (acc ? nreq + 1 : 0) || o_req_cycles != nreq || o_idle_mis !== mis) begin
            failures++;
            $display("FAIL rnd%0d_flow op=%h we=%b addr=%h got stall=%0d req=%0d mis=%b want %0d %0d %b",
                     i, code, we, addr, o_stall_cycles, o_req_cycles, o_idle_mis,
                     acc ? nreq + 1 : 0, nreq, mis);
         end
         if (acc) begin
            checks++;
            if (o_be !== exp_be(code, addr) || o_addr !== (addr & ~32'd3) || o_we !== op_store(code)
                || (op_store(code) && o_wdata !== exp_wdata(code, data)) || o_stable !== 1'b1) begin
               failures++;
               $display("FAIL rnd%0d_bus op=%h got be=%h addr=%h we=%b wdata=%h stable=%b want %h %h %b %h 1",
                        i, code, o_be, o_addr, o_we, o_wdata, o_stable, exp_be(code, addr),
                        addr & ~32'd3, op_store(code), exp_wdata(code, data));
            end
            checks++;
            if (o_done_err !== tmo || o_done_reg_we !== (tmo ? 1'b0 : reg_we_in)
                || o_done_stall !== 1'b0 || o_done_req !== 1'b0 || o_done_csr_we !== csr_we_in) begin
               failures++;
               $display("FAIL rnd%0d_done got err=%b rwe=%b stall=%b req=%b cwe=%b want %b %b 0 0 %b",
                        i, o_done_err, o_done_reg_we, o_done_stall, o_done_req, o_done_csr_we,
                        tmo, tmo ? 1'b0 : reg_we_in, csr_we_in);
            end
            if (!tmo) begin
               checks++;
               if (o_done_reg_wdata !== (op_store(code) ? reg_wdata_in : exp_load(code, addr, rdata))) begin
                  failures++;
                  $display("FAIL rnd%0d_data op=%h addr=%h rdata=%h got %h want %h", i, code, addr,
                           rdata, o_done_reg_wdata,
                           op_store(code) ? reg_wdata_in : exp_load(code, addr, rdata));
               end
            end
         end else if (mis) begin
            checks++;
            if ({o_idle_reg_we, o_idle_csr_we, o_idle_stall, o_idle_req} !== 4'b0000) begin
               failures++;
               $display("FAIL rnd%0d_mis got rwe=%b cwe=%b stall=%b req=%b want 0000", i,
                        o_idle_reg_we, o_idle_csr_we, o_idle_stall, o_idle_req);
            end
         end else begin
            checks++;
            if ({o_done_reg_wdata, o_done_reg_waddr, o_done_reg_we, o_done_csr_we,
                 o_done_csr_wdata, o_done_csr_waddr, o_idle_stall, o_idle_req}
                !== {reg_wdata_in, reg_waddr_in, reg_we_in, csr_we_in,
                     csr_wdata_in, csr_waddr_in, 1'b0, 1'b0}) begin
               failures++;
               $display("FAIL rnd%0d_pass op=%h we=%b got rwd=%h rwa=%h rwe=%b stall=%b want %h %h %b 0",
                        i, code, we, o_done_reg_wdata, o_done_reg_waddr, o_done_reg_we,
                        o_idle_stall, reg_wdata_in, reg_waddr_in, reg_we_in);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lw_wait();
      test_byte_loads();
      test_store_half();
      test_misalign();
      test_timeout();
      test_reset_in_req();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the bus-wait cycles before abort (range 1..255).
REQ-002 SHALL have ports:
- clk_in  in  1  sole clock, rising edge.
- reset_n_in  in  1  asynchronous, active-low reset.
- reg_wdata_in, reg_waddr_in, reg_we_in  in  RDATA_WIDTH/RADDR_WIDTH/1  GPR write from the EXE/MEM register.
- mem_data_in, mem_addr_in  in  DATA_WIDTH/ADDR_WIDTH  store data and effective address.
- mem_we_in  in  1  store flag.
- mem_op_in  in  4  memory op code.
- csr_we_in, csr_wdata_in, csr_waddr_in  in  1/RDATA_WIDTH/CSR_ADDR_WIDTH  CSR write bypass.
- dbus_req_out, dbus_we_out  out  1/1  data-bus request and write strobe.
- dbus_addr_out, dbus_wdata_out  out  ADDR_WIDTH/DATA_WIDTH  word-aligned address and lane-placed data.
- dbus_be_out  out  4  byte enables.
- dbus_ack_in  in  1  bus completion.
- dbus_rdata_in  in  DATA_WIDTH  read word.
- stall_req_out  out  1  stall request to ctrl.
- reg_wdata_out, reg_waddr_out, reg_we_out  out  to MEM/WB.
- csr_we_out, csr_wdata_out, csr_waddr_out  out  to MEM/WB.
- misalign_out, bus_err_out  out  1/1  exception flags.

Function
REQ-003 SHALL decode mem_op_in: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 0110 SB, 0111 SH, 1000 SW; other codes, or a store code with mem_we_in=0, or a load code with mem_we_in=1, SHALL be treated as none.
REQ-004 SHALL implement FSM IDLE, REQ, DONE.
REQ-005 In IDLE with op none: all reg_* and csr_* outputs SHALL equal their inputs combinationally, with stall_req_out=0.
REQ-006 In IDLE with an aligned memory op: stall_req_out=1, reg_we_out=0, csr_we_out=0; next edge latches addr/data/op and enters REQ.
REQ-007 Misaligned ops are: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. For these: no bus access, misalign_out=1, reg_we_out=0, csr_we_out=0, stall_req_out=0; the FSM stays in IDLE.
REQ-008 In REQ: dbus_req_out=1, stall_req_out=1, reg_we_out=0, csr_we_out=0; the bus fields SHALL be stable until ack.
REQ-009 Bus fields: dbus_addr_out={addr[31:2],2'b00}.
- SB: be=0001<<addr[1:0], wdata = byte replicated x4.
- SH: be=0011 if addr[1]=0 else 1100, wdata = half replicated x2.
- SW: be=1111.
- Loads use the same be with dbus_we_out=0.
REQ-010 dbus_ack_in=1 sampled in REQ SHALL capture dbus_rdata_in and enter DONE; an ack in the first REQ cycle is legal (one wait state minimum); ack outside REQ SHALL be ignored.
REQ-011 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; reaching TIMEOUT SHALL enter DONE with the error flag set.
REQ-012 In DONE: stall_req_out=0.
- Load: reg_wdata_out = the selected byte/half of the captured word, sign-extended (LB/LH) or zero-extended (LBU/LHU); reg_we_out=reg_we_in.
- Store: reg_we_out=reg_we_in.
- Timeout: bus_err_out=1 and reg_we_out=0.
- csr_* outputs pass through.
- Next edge returns to IDLE.
REQ-013 Upstream SHALL hold inputs stable while stall_req_out=1 and present a new instruction on every edge where stall_req_out=0.
REQ-014 Latency: non-memory op 0 cycles; memory op = 2 + bus wait cycles until outputs are valid.

Reset
REQ-015 reset_n_in low SHALL immediately force:
- FSM=IDLE, counter=0.
- dbus_req_out=0, dbus_we_out=0, dbus_be_out=0, dbus_addr_out=0, dbus_wdata_out=0.
- stall_req_out=0, reg_we_out=0, csr_we_out=0, misalign_out=0, bus_err_out=0.
- reg_wdata_out=ZERO, reg_waddr_out=ZERO_REG, csr_waddr_out=CSR_ZERO_ADDR, csr_wdata_out=ZERO.
REQ-016 Reset in REQ SHALL abandon the access; a late ack SHALL be ignored.

Structure
REQ-017 mem_op codes SHALL be added to defines.v; widths SHALL come from existing defines.
REQ-018 One sub-module, mem_align, SHALL hold the combinational be/wdata placement and load extraction/extension.

Verification
REQ-019 LW at 0x100, ack after 3 REQ cycles with rdata 0xDEADBEEF -> stall high for 4 cycles, then reg_wdata_out=0xDEADBEEF with reg_we_out=1.
REQ-020 LB at 0x103 with rdata 0x80FF0000 -> reg_wdata_out=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-021 SH at 0x102 with data 0x0000ABCD -> be=1100, wdata=0xABCDABCD, dbus_we_out=1.
REQ-022 LW at 0x101 -> misalign_out=1, no dbus_req_out, reg_we_out=0, no stall.
REQ-023 SW with no ack and TIMEOUT=4 -> bus_err_out=1 in DONE, FSM back to IDLE.
REQ-024 reset_n_in low during REQ -> dbus_req_out=0 immediately, and an ack in the next cycle is ignored.
